// File: rtl/cbus_rr_arbiter_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cbus_rr_arbiter_pkg : FSM encoding and index helpers             |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package cbus_rr_arbiter_pkg;

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } arb_state_t;

   // Increment modulo n; n need not be a power of two.
   function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/common.sv
`default_nettype none
// +------------------------------------------------------------------+
// | common : shared CBus request/response types                      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package common;

   typedef struct packed {
      logic        valid;
      logic        is_write;
      logic [31:0] addr;
      logic [31:0] data;
   } cbus_req_t;

   typedef struct packed {
      logic        ready;
      logic        last;
      logic [31:0] data;
   } cbus_resp_t;

endpackage
`default_nettype wire

// File: rtl/cbus_rr_arbiter_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cbus_rr_arbiter_if : requester/downstream bundle of the arbiter  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface cbus_rr_arbiter_if #(
   parameter int NUM_INPUTS = 2,
   parameter int IDX_W      = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
);
   import common::*;

   cbus_req_t  [NUM_INPUTS-1:0] ireqs;
   cbus_resp_t [NUM_INPUTS-1:0] iresps;
   cbus_req_t                   oreq;
   cbus_resp_t                  oresp;
   logic                        busy;
   logic [IDX_W-1:0]            grant_idx;

   // Environment side: requesters and downstream port.
   modport master (
      output ireqs,
      output oresp,
      input  iresps,
      input  oreq,
      input  busy,
      input  grant_idx
   );

   // Arbiter side.
   modport slave (
      input  ireqs,
      input  oresp,
      output iresps,
      output oreq,
      output busy,
      output grant_idx
   );

endinterface
`default_nettype wire

// File: rtl/cbus_rr_arbiter_picker.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rr_picker : first valid index scanning upward from a start index |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module rr_picker #(
   parameter int NUM_INPUTS = 2,
   parameter int IDX_W      = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
   input  logic [NUM_INPUTS-1:0] i_valid,
   input  logic [IDX_W-1:0]      i_start,
   input  logic                  i_excl_en,
   input  logic [IDX_W-1:0]      i_excl_idx,
   output logic                  o_found,
   output logic [IDX_W-1:0]      o_idx
);

   // Scan from the farthest candidate back to the start so the closest hit wins.
   always_comb begin
      int               c;
      logic [IDX_W-1:0] cand;
      o_found = 1'b0;
      o_idx   = '0;
      c       = 0;
      cand    = '0;
      for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
         c = int'(i_start) + k;
         if (c >= NUM_INPUTS) begin
            c = c - NUM_INPUTS;
         end
         cand = c[IDX_W-1:0];
         if (i_valid[cand] && !(i_excl_en && (cand == i_excl_idx))) begin
            o_found = 1'b1;
            o_idx   = cand;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/cbus_rr_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cbus_rr_arbiter : round-robin owner of the downstream CBus port  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module cbus_rr_arbiter
   import cbus_rr_arbiter_pkg::*;
#(
   parameter int NUM_INPUTS = 2,
   parameter int IDX_W      = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
   input  logic             clk,
   input  logic             reset,
   cbus_rr_arbiter_if.slave bus
);

   arb_state_t              r_state, w_state_d;
   logic [IDX_W-1:0]        r_grant_idx, w_grant_d;
   logic [IDX_W-1:0]        r_rr_ptr, w_ptr_d;
   logic [NUM_INPUTS-1:0]   w_valid;
   logic                    w_last_beat;
   logic                    w_found;
   logic [IDX_W-1:0]        w_pick;
   logic [IDX_W-1:0]        w_pick_inc;

   always_comb begin
      w_valid = '0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
         w_valid[i] = bus.ireqs[i].valid;
      end
   end

   // The finishing owner still shows valid on its last beat, so it is excluded then.
   assign w_last_beat = (r_state == S_BUSY) && bus.oresp.ready && bus.oresp.last;

   rr_picker #(
      .NUM_INPUTS (NUM_INPUTS),
      .IDX_W      (IDX_W)
   ) u_picker (
      .i_valid    (w_valid),
      .i_start    (r_rr_ptr),
      .i_excl_en  (w_last_beat),
      .i_excl_idx (r_grant_idx),
      .o_found    (w_found),
      .o_idx      (w_pick)
   );

   assign w_pick_inc = IDX_W'(wrap_inc(32'(w_pick), NUM_INPUTS));

   always_comb begin
      w_state_d = r_state;
      w_grant_d = r_grant_idx;
      w_ptr_d   = r_rr_ptr;
      case (r_state)
         S_IDLE: begin
            if (w_found) begin
               w_state_d = S_BUSY;
               w_grant_d = w_pick;
               w_ptr_d   = w_pick_inc;
            end
         end
         S_BUSY: begin
            if (w_last_beat) begin
               if (w_found) begin
                  w_grant_d = w_pick;
                  w_ptr_d   = w_pick_inc;
               end else begin
                  w_state_d = S_IDLE;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_grant_idx <= '0;
         r_rr_ptr    <= '0;
      end else begin
         r_state     <= w_state_d;
         r_grant_idx <= w_grant_d;
         r_rr_ptr    <= w_ptr_d;
      end
   end

   assign bus.busy      = (r_state == S_BUSY);
   assign bus.grant_idx = r_grant_idx;
   assign bus.oreq      = bus.busy ? bus.ireqs[r_grant_idx] : '0;

   always_comb begin
      bus.iresps = '0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
         if (bus.busy && (r_grant_idx == IDX_W'(i))) begin
            bus.iresps[i] = bus.oresp;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_cbus_rr_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_cbus_rr_arbiter : directed and random checks vs. a model      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_cbus_rr_arbiter;
   import common::*;

   localparam int c_n = 3;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   cbus_rr_arbiter_if #(.NUM_INPUTS(c_n)) bus ();

   cbus_rr_arbiter #(.NUM_INPUTS(c_n)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int         checks = 0;
   int         errors = 0;
   bit         m_busy;
   int         m_owner;
   int         m_ptr;
   bit [c_n-1:0] seen_last;

   task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // First requester at or after start (mod c_n) that is valid and not excluded.
   function automatic int ref_pick(input int start, input int excl);
      for (int k = 0; k < c_n; k++) begin
         int i;
         i = (start + k) % c_n;
         if (bus.ireqs[i].valid && i != excl) return i;
      end
      return -1;
   endfunction

   task automatic check_outputs();
      cbus_req_t  exp_req;
      cbus_resp_t exp_resp;
      check_val("busy", 128'(bus.busy), 128'(m_busy));
      if (m_busy) check_val("grant_idx", 128'(bus.grant_idx), 128'(m_owner));
      exp_req = m_busy ? bus.ireqs[m_owner] : '0;
      check_val("oreq", 128'(bus.oreq), 128'(exp_req));
      for (int j = 0; j < c_n; j++) begin
         exp_resp = (m_busy && j == m_owner) ? bus.oresp : '0;
         check_val($sformatf("iresps%0d", j), 128'(bus.iresps[j]), 128'(exp_resp));
      end
   endtask

   task automatic model_step();
      int p;
      bit fin;
      fin       = m_busy && bus.oresp.ready && bus.oresp.last;
      seen_last = '0;
      if (fin) seen_last[m_owner] = 1'b1;
      if (!m_busy) begin
         p = ref_pick(m_ptr, -1);
         if (p >= 0) begin
            m_busy = 1'b1; m_owner = p; m_ptr = (p + 1) % c_n;
         end
      end else if (fin) begin
         p = ref_pick(m_ptr, m_owner);
         if (p >= 0) begin
            m_owner = p; m_ptr = (p + 1) % c_n;
         end else begin
            m_busy = 1'b0;
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      check_outputs();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic new_req(input int i);
      bus.ireqs[i].valid    = 1'b1;
      bus.ireqs[i].is_write = 1'($urandom);
      bus.ireqs[i].addr     = $urandom;
      bus.ireqs[i].data     = $urandom;
   endtask

   task automatic set_resp(input bit rdy, input bit lst);
      bus.oresp.ready = rdy;
      bus.oresp.last  = lst;
      bus.oresp.data  = $urandom;
   endtask

   task automatic apply_reset();
      reset     = 1'b1;
      bus.ireqs = '0;
      bus.oresp = '0;
      m_busy    = 1'b0; m_owner = 0; m_ptr = 0;
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_busy", 128'(bus.busy), 128'(0));
      check_val("rst_grant", 128'(bus.grant_idx), 128'(0));
      check_val("rst_oreq", 128'(bus.oreq), 128'(0));
      check_val("rst_iresps", 128'(bus.iresps), 128'(0));
      reset = 1'b0;
   endtask

   initial begin
      apply_reset();

      // Lone requester 1, short burst, then pointer has wrapped to 2.
      tick();
      new_req(1);
      tick();
      check_val("s1_grant", 128'(bus.grant_idx), 128'(1));
      check_val("s1_oreq", 128'(bus.oreq), 128'(bus.ireqs[1]));
      set_resp(1'b1, 1'b0);
      tick();
      set_resp(1'b1, 1'b1);
      tick();
      check_val("s1_idle", 128'(bus.busy), 128'(0));
      bus.ireqs[1].valid = 1'b0;
      set_resp(1'b0, 1'b0);
      new_req(0); new_req(1); new_req(2);
      tick();
      check_val("s1_ptr_wrap", 128'(bus.grant_idx), 128'(2));
      bus.ireqs = '0;
      tick();
      tick();

      // Fairness: everyone requesting, single-beat transactions.
      apply_reset();
      new_req(0); new_req(1); new_req(2);
      set_resp(1'b1, 1'b1);
      for (int k = 0; k < 6; k++) begin
         tick();
         check_val($sformatf("fair_busy%0d", k), 128'(bus.busy), 128'(1));
         check_val($sformatf("fair_order%0d", k), 128'(bus.grant_idx), 128'(k % 3));
      end

      // Handover exclusion: the finishing owner cannot be re-granted immediately.
      apply_reset();
      new_req(0);
      tick();
      set_resp(1'b1, 1'b1);
      tick();
      check_val("excl_idle", 128'(bus.busy), 128'(0));
      tick();
      check_val("excl_regrant_busy", 128'(bus.busy), 128'(1));
      check_val("excl_regrant_idx", 128'(bus.grant_idx), 128'(0));
      check_val("excl_regrant_oreq", 128'(bus.oreq), 128'(bus.ireqs[0]));
      set_resp(1'b0, 1'b0);

      // Burst by requester 1 while requester 0 waits.
      apply_reset();
      new_req(1);
      tick();
      new_req(0);
      for (int b = 0; b < 4; b++) begin
         set_resp(1'b1, b == 3);
         check_val($sformatf("burst_grant%0d", b), 128'(bus.grant_idx), 128'(1));
         check_val($sformatf("burst_iresp0_%0d", b), 128'(bus.iresps[0]), 128'(0));
         tick();
      end
      check_val("burst_handover", 128'(bus.grant_idx), 128'(0));
      check_val("burst_handover_busy", 128'(bus.busy), 128'(1));

      // Asynchronous reset in the middle of beat 2.
      apply_reset();
      new_req(1);
      tick();
      set_resp(1'b1, 1'b0);
      tick();
      #2 reset = 1'b1;
      #1;
      check_val("mid_rst_busy", 128'(bus.busy), 128'(0));
      check_val("mid_rst_grant", 128'(bus.grant_idx), 128'(0));
      check_val("mid_rst_oreq", 128'(bus.oreq), 128'(0));
      check_val("mid_rst_iresps", 128'(bus.iresps), 128'(0));
      m_busy = 1'b0; m_owner = 0; m_ptr = 0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      set_resp(1'b0, 1'b0);
      new_req(0); new_req(2);
      tick();
      check_val("rst_restart", 128'(bus.grant_idx), 128'(0));

      // Random traffic honouring the requester contract.
      apply_reset();
      for (int t = 0; t < 600; t++) begin
         tick();
         for (int i = 0; i < c_n; i++) begin
            if (!bus.ireqs[i].valid) begin
               if ($urandom_range(1, 0) == 1) new_req(i);
            end else if (seen_last[i]) begin
               if ($urandom_range(2, 0) == 0) bus.ireqs[i].valid = 1'b0;
               else new_req(i);
            end
         end
         set_resp($urandom_range(3, 0) != 0, $urandom_range(2, 0) == 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
